// File: rtl/cordic_add_subt_pkg.sv
// Shared types and sizing helpers for the segmented CORDIC adder/subtractor.
package cordic_add_subt_pkg;

    localparam int unsigned DefW   = 32;
    localparam int unsigned DefSeg = 8;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StDone = 2'b10
    } state_e;

    // Segment counter width; a single-segment build still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned nseg);
        return (nseg > 1) ? $clog2(nseg) : 1;
    endfunction

endpackage

// File: rtl/cordic_add_subt_seg_adder.sv
// Combinational SEG-bit ripple adder with carry in/out.
module seg_adder
    import cordic_add_subt_pkg::*;
#(
    parameter int unsigned SEG = DefSeg
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

endmodule

// File: rtl/cordic_add_subt_seg.sv
// Two's-complement add/subtract computed one SEG-bit segment per clock, with a
// beg/ready/ack handshake towards the CORDIC control FSM.
module cordic_add_subt_seg
    import cordic_add_subt_pkg::*;
#(
    parameter int unsigned W   = DefW,
    parameter int unsigned SEG = DefSeg
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         beg_add_subt,
    input  logic         ack_add_subt,
    input  logic         add_subt,
    input  logic [W-1:0] Data_X,
    input  logic [W-1:0] Data_Y,
    output logic         ready_add_subt,
    output logic [W-1:0] add_subt_result,
    output logic         overflow_flag,
    output logic         busy
);

    localparam int unsigned NSEG = W / SEG;
    localparam int unsigned CW   = cnt_width(NSEG);

    state_e         state_q, state_d;
    logic [W-1:0]   op_a_q, op_a_d;
    logic [W-1:0]   op_b_q, op_b_d;
    logic [W-1:0]   result_q, result_d;
    logic           carry_q, carry_d;
    logic           ovf_q, ovf_d;
    logic           ready_q, ready_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [31:0]    seg_base;
    logic [W-1:0]   a_shift, b_shift, seg_mask, seg_ins;
    logic [SEG-1:0] seg_a, seg_b, seg_sum;
    logic           seg_cout;
    logic           last_seg;

    // One adder shared by all segments; operands are shifted down to it.
    assign seg_base = 32'(cnt_q) * 32'(SEG);
    assign a_shift  = op_a_q >> seg_base;
    assign b_shift  = op_b_q >> seg_base;
    assign seg_a    = a_shift[SEG-1:0];
    assign seg_b    = b_shift[SEG-1:0];
    assign seg_mask = W'({SEG{1'b1}}) << seg_base;
    assign seg_ins  = W'(seg_sum) << seg_base;
    assign last_seg = (cnt_q == CW'(NSEG - 1));

    seg_adder #(
        .SEG (SEG)
    ) u_seg_adder (
        .a    (seg_a),
        .b    (seg_b),
        .cin  (carry_q),
        .sum  (seg_sum),
        .cout (seg_cout)
    );

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        ready_d  = ready_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (beg_add_subt) begin
                    // Subtraction as A + ~B + 1, the +1 entering as the first carry.
                    op_a_d  = Data_X;
                    op_b_d  = add_subt ? ~Data_Y : Data_Y;
                    carry_d = add_subt;
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                result_d = (result_q & ~seg_mask) | seg_ins;
                carry_d  = seg_cout;
                cnt_d    = last_seg ? '0 : cnt_q + CW'(1);
                if (last_seg) begin
                    state_d = StDone;
                    ready_d = 1'b1;
                    ovf_d   = (op_a_q[W-1] == op_b_q[W-1]) && (seg_sum[SEG-1] != op_a_q[W-1]);
                end
            end
            StDone: begin
                if (ack_add_subt) begin
                    state_d = StIdle;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            ready_q  <= ready_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ready_add_subt  = ready_q;
    assign add_subt_result = result_q;
    assign overflow_flag   = ovf_q;
    assign busy            = (state_q == StCalc) || (state_q == StDone);

endmodule

// File: tb/tb_cordic_add_subt_seg.sv
// Scoreboard bench for cordic_add_subt_seg: expected results are queued at
// capture time and compared when ready_add_subt rises.
module tb_cordic_add_subt_seg;

    logic        clk = 1'b0;
    logic        reset;
    logic        beg_add_subt;
    logic        ack_add_subt;
    logic        add_subt;
    logic [31:0] Data_X;
    logic [31:0] Data_Y;
    logic        ready_add_subt;
    logic [31:0] add_subt_result;
    logic        overflow_flag;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    cordic_add_subt_seg dut (
        .clk             (clk),
        .reset           (reset),
        .beg_add_subt    (beg_add_subt),
        .ack_add_subt    (ack_add_subt),
        .add_subt        (add_subt),
        .Data_X          (Data_X),
        .Data_Y          (Data_Y),
        .ready_add_subt  (ready_add_subt),
        .add_subt_result (add_subt_result),
        .overflow_flag   (overflow_flag),
        .busy            (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic sub);
        exp_t e;
        e.res = sub ? (x - y) : (x + y);
        if (sub) e.ovf = (x[31] != y[31]) && (e.res[31] != x[31]);
        else     e.ovf = (x[31] == y[31]) && (e.res[31] != x[31]);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive operands with beg high for the capture edge and queue the expectation.
    task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic sub);
        Data_X       = x;
        Data_Y       = y;
        add_subt     = sub;
        beg_add_subt = 1'b1;
        step();
        beg_add_subt = 1'b0;
        exp_q.push_back(model(x, y, sub));
    endtask

    task automatic wait_ready(output int edges);
        edges = 0;
        while (!ready_add_subt && edges < 20) begin
            step();
            edges++;
        end
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check_val({tag, "_result"}, add_subt_result, e.res);
        check_val({tag, "_ovf"}, 32'(overflow_flag), 32'(e.ovf));
        check_val({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic do_ack(input string tag);
        logic [31:0] held;
        held         = add_subt_result;
        ack_add_subt = 1'b1;
        step();
        ack_add_subt = 1'b0;
        check_val({tag, "_ack_ready"}, 32'(ready_add_subt), 32'd0);
        check_val({tag, "_ack_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_ack_hold"}, add_subt_result, held);
    endtask

    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic sub);
        int edges;
        start_op(x, y, sub);
        wait_ready(edges);
        check_val({tag, "_latency"}, 32'(edges), 32'd4);
        check_result(tag);
        do_ack(tag);
    endtask

    initial begin
        int edges;
        logic [31:0] rx, ry;
        reset        = 1'b0;
        ack_add_subt = 1'b0;
        beg_add_subt = 1'b1;
        add_subt     = 1'b0;
        Data_X       = 32'h0000_00FF;
        Data_Y       = 32'h0000_0001;

        // Reset dominates a pending start request.
        step();
        step();
        check_val("rst_ready", 32'(ready_add_subt), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_result", add_subt_result, 32'h0);
        check_val("rst_ovf", 32'(overflow_flag), 32'd0);
        reset = 1'b1;

        // Carry ripples across segment boundaries; outputs hold without ack.
        start_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
        check_val("cap_busy", 32'(busy), 32'd1);
        wait_ready(edges);
        check_val("carry_latency", 32'(edges), 32'd4);
        check_val("carry_res_const", add_subt_result, 32'h0000_0100);
        check_result("carry");
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("hold_ready", 32'(ready_add_subt), 32'd1);
            check_val("hold_result", add_subt_result, 32'h0000_0100);
        end
        do_ack("carry");
        check_val("after_ack_result", add_subt_result, 32'h0000_0100);

        run_op("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b1);
        check_val("sub_neg_const", add_subt_result, 32'hFFFF_FFFE);
        run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1);
        check_val("sub_ovf_const", add_subt_result, 32'h7FFF_FFFF);
        check_val("sub_ovf_flag", 32'(overflow_flag), 32'd1);
        run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        check_val("add_ovf_const", add_subt_result, 32'h8000_0000);
        run_op("add_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check_val("add_neg_flag", 32'(overflow_flag), 32'd0);

        // Inputs changing during CALC must not disturb the captured operation.
        start_op(32'h0000_1234, 32'h0000_0010, 1'b0);
        for (int i = 0; i < 2; i++) begin
            Data_X       = 32'hDEAD_BEEF;
            add_subt     = ~add_subt;
            beg_add_subt = ~beg_add_subt;
            step();
        end
        beg_add_subt = 1'b1;
        wait_ready(edges);
        check_val("iso_latency", 32'(edges + 2), 32'd4);
        check_val("iso_const", add_subt_result, 32'h0000_1244);
        check_result("iso");
        // beg together with ack in DONE: release only, no new start.
        ack_add_subt = 1'b1;
        step();
        ack_add_subt = 1'b0;
        beg_add_subt = 1'b0;
        check_val("begack_busy", 32'(busy), 32'd0);
        check_val("begack_ready", 32'(ready_add_subt), 32'd0);
        step();
        check_val("begack_idle", 32'(busy), 32'd0);

        // Reset on the second CALC edge aborts the operation.
        Data_X       = 32'h0000_0011;
        Data_Y       = 32'h0000_0022;
        add_subt     = 1'b0;
        beg_add_subt = 1'b1;
        step();
        beg_add_subt = 1'b0;
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_val("midrst_busy", 32'(busy), 32'd0);
        check_val("midrst_ready", 32'(ready_add_subt), 32'd0);
        check_val("midrst_result", add_subt_result, 32'h0);
        check_val("midrst_ovf", 32'(overflow_flag), 32'd0);
        run_op("post_rst", 32'h0000_0003, 32'h0000_0004, 1'b0);
        check_val("post_rst_const", add_subt_result, 32'h0000_0007);

        for (int i = 0; i < 6; i++) begin
            rx = $urandom;
            ry = $urandom;
            run_op("rand", rx, ry, 1'($urandom_range(0, 1)));
        end

        check_val("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_add_subt_seg.md
Name: cordic_add_subt_seg

Overview:
- Fixed-point two's-complement adder/subtractor that serves the CORDIC control FSM.
- The FSM starts it with beg_add_subt and releases it with ack_add_subt; the block answers with ready_add_subt.
- Computes X/Y/Z iteration updates (Data_X ± Data_Y) one SEG-bit segment per clock, giving a short carry chain for timing.
- Result and overflow are held stable until the FSM acknowledges them.

Parameters:
- W, 32, operand/result width in bits; must be an integer multiple of SEG.
- SEG, 8, segment width processed per clock. NSEG = W/SEG (default 4).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low; 0 at a rising edge resets the block.
- beg_add_subt  input  1  start request from the FSM; sampled only in IDLE.
- ack_add_subt  input  1  FSM has taken the result; sampled only in DONE.
- add_subt  input  1  0 = Data_X + Data_Y, 1 = Data_X - Data_Y; captured with the operands.
- Data_X  input  W  first operand, two's complement.
- Data_Y  input  W  second operand, two's complement.
- ready_add_subt  output  1  result valid; registered.
- add_subt_result  output  W  result register.
- overflow_flag  output  1  signed overflow of the last operation; registered.
- busy  output  1  high in CALC and DONE.

Behaviour:
- Reset (reset=0 at an edge): state IDLE; ready_add_subt=0, add_subt_result=0, overflow_flag=0, busy=0, segment counter=0, carry=0, operand regs=0. Reset wins over every other input, including mid-CALC.
- States: IDLE, CALC, DONE. Two-bit encoding: IDLE=00, CALC=01, DONE=10; 11 is illegal and recovers to IDLE.
- IDLE, beg_add_subt=1 at an edge:
  - opA <= Data_X.
  - opB <= add_subt ? ~Data_Y : Data_Y.
  - carry <= add_subt.
  - seg_cnt <= 0; go to CALC.
  - beg_add_subt is level-sensitive: if still high when the block re-enters IDLE, a new operation starts. The FSM must drop it.
- CALC, each edge: {cout, sum} = opA[seg] + opB[seg] + carry, where seg = seg_cnt*SEG +: SEG.
  - add_subt_result[seg] <= sum; carry <= cout; seg_cnt increments.
  - On the edge where seg_cnt == NSEG-1: go to DONE, ready_add_subt <= 1, and overflow_flag <= (opA[W-1] == opB[W-1]) && (final sum MSB != opA[W-1]).
- Latency: ready_add_subt rises exactly NSEG edges after the edge that captured beg_add_subt (4 with defaults).
- Inputs during CALC/DONE: Data_X, Data_Y, add_subt and beg_add_subt are ignored. The operation uses only the captured registers.
- DONE: ready_add_subt=1; add_subt_result and overflow_flag held. On ack_add_subt=1 at an edge: go to IDLE, ready_add_subt <= 0.
- After ack: add_subt_result and overflow_flag keep their values until the next operation overwrites them.
- Simultaneous beg and ack in DONE: ack is honoured and beg is not captured. A new start needs beg high while in IDLE.
- ack_add_subt in IDLE/CALC has no effect (no early release).
- Wrap-around: the result is modulo 2^W; no saturation; overflow is reported only via overflow_flag.
- Throughput: one operation per NSEG+2 cycles minimum (capture, NSEG segments, ack).

Decomposition:
- Package cordic_add_subt_pkg holds: state localparams (IDLE/CALC/DONE), default W/SEG, and the NSEG and counter-width derivation ($clog2(NSEG), minimum 1).
- Sub-module seg_adder: combinational SEG-bit adder with cin/cout, instantiated once and muxed by seg_cnt.
- The FSM, counter and registers stay in cordic_add_subt_seg.

Test Plan:
- Reset: hold reset=0 for 2 edges with beg=1 → ready=0, busy=0, result=0x00000000, overflow=0; release → operation starts on the next edge.
- Carry across segments: 0x000000FF + 0x00000001, add_subt=0 → ready high 4 edges after capture, result=0x00000100, overflow=0. Hold ack=0 for 5 cycles → outputs stable. ack=1 → ready=0 next edge, result still 0x00000100.
- Subtract: 0x00000005 - 0x00000007 → result=0xFFFFFFFE, overflow=0. Then 0x80000000 - 0x00000001 → 0x7FFFFFFF, overflow=1.
- Add overflow: 0x7FFFFFFF + 0x00000001 → 0x80000000, overflow=1. Then 0xFFFFFFFF + 0xFFFFFFFF → 0xFFFFFFFE, overflow=0.
- Input isolation: start 0x00001234 + 0x00000010, then change Data_X to 0xDEADBEEF and toggle add_subt/beg during CALC → result=0x00001244. Assert beg and ack together in DONE → returns to IDLE without starting.
- Reset mid-operation: reset=0 on the 2nd CALC edge → next state IDLE, all outputs 0. Then 0x00000003 + 0x00000004 completes normally with 0x00000007.
